// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type for the fabric.
package ahb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StErr1,
    StErr2
  } dflt_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in slave for unmapped addresses: two-cycle ERROR response and a
// saturating count of the errors it has issued.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  output logic        ready,
  output logic        resp,
  output logic [15:0] err_count
);

  dflt_state_e state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ready     <= 1'b1;
      resp      <= RESP_OKAY;
      err_count <= 16'h0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StErr1;
            ready   <= 1'b0;
            resp    <= RESP_ERROR;
          end
        end
        StErr1: begin
          state_q <= StErr2;
          ready   <= 1'b1;
          resp    <= RESP_ERROR;
          if (err_count != 16'hFFFF) begin
            err_count <= err_count + 16'h0001;
          end
        end
        StErr2: begin
          // ERR2 drives HREADY high, so a new unmapped transfer may start here
          if (accept) begin
            state_q <= StErr1;
            ready   <= 1'b0;
            resp    <= RESP_ERROR;
          end else begin
            state_q <= StIdle;
            ready   <= 1'b1;
            resp    <= RESP_OKAY;
          end
        end
        default: begin
          state_q <= StIdle;
          ready   <= 1'b1;
          resp    <= RESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_lite_fabric.sv
// Single-master AHB-Lite interconnect: address decode onto NSLAVES ports plus a
// default slave, data-phase tracking and a combinational return-path mux.
module ahb_lite_fabric
  import ahb_pkg::*;
#(
  parameter int unsigned           NSLAVES = 2,
  parameter int unsigned           WORDS   = 4,
  // Slave i occupies bits [32*i +: 32]; slave 1 is the upper word here.
  parameter logic [NSLAVES*32-1:0] BASE    = {32'h2000_0000, 32'h0000_0000},
  parameter logic [NSLAVES*32-1:0] MASK    = {32'hE000_0000, 32'hE000_0000}
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [31:0]                   HADDR,
  input  logic                          HWRITE,
  input  logic [1:0]                    HTRANS,
  input  logic [WORDS*32-1:0]           HWDATA,
  output logic [WORDS*32-1:0]           HRDATA,
  output logic                          HREADY,
  output logic                          HRESP,
  output logic [NSLAVES-1:0]            HSEL_S,
  output logic [31:0]                   HADDR_S,
  output logic                          HWRITE_S,
  output logic [1:0]                    HTRANS_S,
  output logic [WORDS*32-1:0]           HWDATA_S,
  output logic                          HREADY_S,
  input  logic [NSLAVES*WORDS*32-1:0]   HRDATA_S,
  input  logic [NSLAVES-1:0]            HREADYOUT_S,
  input  logic [NSLAVES-1:0]            HRESP_S,
  output logic [15:0]                   ERRCOUNT
);

  localparam int unsigned DW    = WORDS * 32;
  localparam int unsigned IDX_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  logic [NSLAVES-1:0] match;
  logic [NSLAVES-1:0] win;
  logic [NSLAVES:0]   below;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;

  logic               dp_active_q;
  logic               dp_dflt_q;
  logic [IDX_W-1:0]   dp_idx_q;

  logic [NSLAVES-1:0] own;
  logic [DW-1:0]      rd_term [NSLAVES];

  logic               dflt_ready;
  logic               dflt_resp;
  logic               dflt_accept;

  assign HADDR_S  = HADDR;
  assign HWRITE_S = HWRITE;
  assign HTRANS_S = HTRANS;
  assign HWDATA_S = HWDATA;
  assign HREADY_S = HREADY;

  // below[i] is set when any lower-index region matched, giving lowest-index priority
  assign below[0] = 1'b0;

  for (genvar i = 0; i < NSLAVES; i++) begin : g_dec
    assign match[i]     = (HADDR & MASK[32*i +: 32]) == BASE[32*i +: 32];
    assign below[i+1]   = below[i] | match[i];
    assign win[i]       = match[i] & ~below[i];
    assign HSEL_S[i]    = win[i] & HTRANS[1];
  end

  assign hit = below[NSLAVES];

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (win[i]) begin
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_active_q <= 1'b0;
      dp_dflt_q   <= 1'b0;
      dp_idx_q    <= '0;
    end else if (HREADY) begin
      dp_active_q <= HTRANS[1];
      dp_dflt_q   <= ~hit;
      dp_idx_q    <= hit_idx;
    end
  end

  assign dflt_accept = HREADY & HTRANS[1] & ~hit;

  ahb_default_slave u_default_slave (
    .clk       (HCLK),
    .rst       (HRESET),
    .accept    (dflt_accept),
    .ready     (dflt_ready),
    .resp      (dflt_resp),
    .err_count (ERRCOUNT)
  );

  for (genvar i = 0; i < NSLAVES; i++) begin : g_mux
    assign own[i]     = dp_active_q & ~dp_dflt_q & (dp_idx_q == IDX_W'(i));
    assign rd_term[i] = own[i] ? HRDATA_S[i*DW +: DW] : '0;
  end

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = RESP_OKAY;
    for (int i = 0; i < NSLAVES; i++) begin
      HRDATA = HRDATA | rd_term[i];
    end
    if (|own) begin
      HREADY = |(own & HREADYOUT_S);
      HRESP  = |(own & HRESP_S);
    end else if (dp_active_q && dp_dflt_q) begin
      HREADY = dflt_ready;
      HRESP  = dflt_resp;
    end
  end

endmodule

// File: tb/tb_ahb_lite_fabric.sv
// Scoreboard bench for ahb_lite_fabric: expected data-phase responses are queued
// when the address phase is driven and popped as each data-phase cycle is sampled.
module tb_ahb_lite_fabric;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [127:0] D_A5 = {16{8'hA5}};
  localparam logic [127:0] D_5A = {16{8'h5A}};
  localparam logic [127:0] D_33 = {16{8'h33}};
  localparam logic [127:0] D_C3 = {16{8'hC3}};

  typedef struct {
    logic         rdy;
    logic         resp;
    logic [127:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic         HCLK = 1'b0;
  logic         HRESET = 1'b0;
  logic [31:0]  HADDR = 32'h0;
  logic         HWRITE = 1'b0;
  logic [1:0]   HTRANS = T_IDLE;
  logic [127:0] HWDATA = '0;
  logic [127:0] HRDATA;
  logic         HREADY;
  logic         HRESP;
  logic [1:0]   HSEL_S;
  logic [31:0]  HADDR_S;
  logic         HWRITE_S;
  logic [1:0]   HTRANS_S;
  logic [127:0] HWDATA_S;
  logic         HREADY_S;
  logic [255:0] HRDATA_S = '0;
  logic [1:0]   HREADYOUT_S = 2'b11;
  logic [1:0]   HRESP_S = 2'b00;
  logic [15:0]  ERRCOUNT;

  logic [127:0] o_hrdata;
  logic         o_hready, o_hresp, o_hwrite_s, o_hready_s;
  logic [1:0]   o_hsel_s, o_htrans_s;
  logic [31:0]  o_haddr_s;
  logic [127:0] o_hwdata_s;
  logic [15:0]  o_errcount;

  always #5 HCLK = ~HCLK;

  ahb_lite_fabric dut (
    .HCLK (HCLK), .HRESET (HRESET), .HADDR (HADDR), .HWRITE (HWRITE), .HTRANS (HTRANS),
    .HWDATA (HWDATA), .HRDATA (HRDATA), .HREADY (HREADY), .HRESP (HRESP), .HSEL_S (HSEL_S),
    .HADDR_S (HADDR_S), .HWRITE_S (HWRITE_S), .HTRANS_S (HTRANS_S), .HWDATA_S (HWDATA_S),
    .HREADY_S (HREADY_S), .HRDATA_S (HRDATA_S), .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S (HRESP_S), .ERRCOUNT (ERRCOUNT)
  );

  // Overlapping regions: both slaves decode address 0.
  ahb_lite_fabric #(
    .NSLAVES (2), .WORDS (4),
    .BASE ({32'h0000_0000, 32'h0000_0000}),
    .MASK ({32'hE000_0000, 32'hE000_0000})
  ) dut_ovl (
    .HCLK (HCLK), .HRESET (HRESET), .HADDR (HADDR), .HWRITE (HWRITE), .HTRANS (HTRANS),
    .HWDATA (HWDATA), .HRDATA (o_hrdata), .HREADY (o_hready), .HRESP (o_hresp),
    .HSEL_S (o_hsel_s), .HADDR_S (o_haddr_s), .HWRITE_S (o_hwrite_s), .HTRANS_S (o_htrans_s),
    .HWDATA_S (o_hwdata_s), .HREADY_S (o_hready_s), .HRDATA_S (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S), .HRESP_S (HRESP_S), .ERRCOUNT (o_errcount)
  );

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset;
    #3 HRESET = 1'b1;
    #1;
    checks++;
    if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== '0) begin
      errors++;
      $display("FAIL reset_return: rdy=%b resp=%b data=%h, want rdy=1 resp=0 data=0",
               HREADY, HRESP, HRDATA);
    end
    checks++;
    if (ERRCOUNT !== 16'h0 || HSEL_S !== 2'b00) begin
      errors++;
      $display("FAIL reset_count_sel: errcount=%h hsel=%b, want 0 and 00", ERRCOUNT, HSEL_S);
    end
    #8 HRESET = 1'b0;
    tick();
  endtask

  task automatic test_read;
    exp_t e;
    HRDATA_S    = {D_A5, D_5A};
    HREADYOUT_S = 2'b11;
    HRESP_S     = 2'b00;
    HADDR  = 32'h2000_0010;
    HWRITE = 1'b0;
    HTRANS = T_NONSEQ;
    #1;
    checks++;
    if (HSEL_S !== 2'b10) begin
      errors++;
      $display("FAIL read_hsel: got %b, want 10", HSEL_S);
    end
    checks++;
    if (HADDR_S !== 32'h2000_0010 || HTRANS_S !== T_NONSEQ || HREADY_S !== 1'b1) begin
      errors++;
      $display("FAIL read_broadcast: haddr=%h htrans=%b hready_s=%b, want 20000010 10 1",
               HADDR_S, HTRANS_S, HREADY_S);
    end
    sb.push_back('{rdy: 1'b1, resp: 1'b0, data: D_A5});
    tick();
    HTRANS = T_IDLE;
    e = sb.pop_front();
    checks++;
    if (HREADY !== e.rdy || HRESP !== e.resp || HRDATA !== e.data) begin
      errors++;
      $display("FAIL read_data: rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
               HREADY, HRESP, HRDATA, e.rdy, e.resp, e.data);
    end
    tick();
  endtask

  task automatic test_wait_states;
    exp_t e;
    int   lows = 0;
    HRDATA_S    = {D_C3, D_33};
    HREADYOUT_S = 2'b11;
    HADDR  = 32'h0000_0010;
    HWRITE = 1'b1;
    HTRANS = T_NONSEQ;
    tick();
    HWDATA         = {4{32'hDEAD_BEEF}};
    HREADYOUT_S[0] = 1'b0;
    HADDR  = 32'h2000_0004;
    HWRITE = 1'b0;
    HTRANS = T_NONSEQ;
    #1;
    checks++;
    if (HSEL_S !== 2'b10 || HWDATA_S !== {4{32'hDEAD_BEEF}}) begin
      errors++;
      $display("FAIL stall_hsel: hsel=%b hwdata_s=%h, want 10 and deadbeef x4", HSEL_S, HWDATA_S);
    end
    for (int k = 0; k < 3; k++) sb.push_back('{rdy: 1'b0, resp: 1'b0, data: D_33});
    sb.push_back('{rdy: 1'b1, resp: 1'b0, data: D_33});
    for (int k = 0; k < 4; k++) begin
      if (k == 3) HREADYOUT_S[0] = 1'b1;
      #1;
      e = sb.pop_front();
      checks++;
      if (HREADY !== e.rdy || HRESP !== e.resp || HRDATA !== e.data) begin
        errors++;
        $display("FAIL wait_cycle%0d: rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
                 k, HREADY, HRESP, HRDATA, e.rdy, e.resp, e.data);
      end
      if (HREADY === 1'b0) lows++;
      tick();
    end
    HTRANS = T_IDLE;
    sb.push_back('{rdy: 1'b1, resp: 1'b0, data: D_C3});
    e = sb.pop_front();
    checks++;
    if (HREADY !== e.rdy || HRESP !== e.resp || HRDATA !== e.data) begin
      errors++;
      $display("FAIL wait_second: rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
               HREADY, HRESP, HRDATA, e.rdy, e.resp, e.data);
    end
    checks++;
    if (lows !== 3) begin
      errors++;
      $display("FAIL wait_count: got %0d low cycles, want 3", lows);
    end
    tick();
  endtask

  task automatic test_error;
    exp_t e;
    HRDATA_S    = {D_C3, D_33};
    HREADYOUT_S = 2'b11;
    HADDR  = 32'h4000_0000;
    HTRANS = T_NONSEQ;
    #1;
    checks++;
    if (HSEL_S !== 2'b00) begin
      errors++;
      $display("FAIL err_hsel: got %b, want 00", HSEL_S);
    end
    sb.push_back('{rdy: 1'b0, resp: 1'b1, data: '0});
    sb.push_back('{rdy: 1'b1, resp: 1'b1, data: '0});
    sb.push_back('{rdy: 1'b1, resp: 1'b0, data: D_C3});
    tick();
    HTRANS = T_IDLE;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        // back-to-back: next transfer presented during ERR2
        HADDR  = 32'h2000_0020;
        HTRANS = T_NONSEQ;
      end
      #1;
      e = sb.pop_front();
      checks++;
      if (HREADY !== e.rdy || HRESP !== e.resp || HRDATA !== e.data) begin
        errors++;
        $display("FAIL err_cycle%0d: rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
                 k, HREADY, HRESP, HRDATA, e.rdy, e.resp, e.data);
      end
      tick();
    end
    HTRANS = T_IDLE;
    e = sb.pop_front();
    checks++;
    if (HREADY !== e.rdy || HRESP !== e.resp || HRDATA !== e.data) begin
      errors++;
      $display("FAIL err_after: rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
               HREADY, HRESP, HRDATA, e.rdy, e.resp, e.data);
    end
    checks++;
    if (ERRCOUNT !== 16'd1) begin
      errors++;
      $display("FAIL err_count: got %0d, want 1", ERRCOUNT);
    end
    HADDR  = 32'h4000_0000;
    HTRANS = T_IDLE;
    sb.push_back('{rdy: 1'b1, resp: 1'b0, data: '0});
    tick();
    e = sb.pop_front();
    checks++;
    if (HREADY !== e.rdy || HRESP !== e.resp || HRDATA !== e.data || ERRCOUNT !== 16'd1) begin
      errors++;
      $display("FAIL idle_unmapped: rdy=%b resp=%b data=%h cnt=%0d, want rdy=1 resp=0 data=0 cnt=1",
               HREADY, HRESP, HRDATA, ERRCOUNT);
    end
    tick();
  endtask

  task automatic test_overlap;
    HADDR  = 32'h0000_0000;
    HTRANS = T_NONSEQ;
    #1;
    checks++;
    if (o_hsel_s !== 2'b01) begin
      errors++;
      $display("FAIL overlap_hsel: got %b, want 01", o_hsel_s);
    end
    checks++;
    if (HSEL_S !== 2'b01) begin
      errors++;
      $display("FAIL base_hsel0: got %b, want 01", HSEL_S);
    end
    HTRANS = T_IDLE;
    tick();
  endtask

  task automatic test_reset_in_error;
    exp_t e;
    HADDR  = 32'h4000_0000;
    HTRANS = T_NONSEQ;
    sb.push_back('{rdy: 1'b0, resp: 1'b1, data: '0});
    tick();
    HTRANS = T_IDLE;
    e = sb.pop_front();
    checks++;
    if (HREADY !== e.rdy || HRESP !== e.resp) begin
      errors++;
      $display("FAIL rst_err1: rdy=%b resp=%b, want rdy=%b resp=%b", HREADY, HRESP, e.rdy, e.resp);
    end
    #1 HRESET = 1'b1;
    #1;
    checks++;
    if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== '0 || ERRCOUNT !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_err: rdy=%b resp=%b data=%h cnt=%0d, want 1 0 0 0",
               HREADY, HRESP, HRDATA, ERRCOUNT);
    end
    #1 HRESET = 1'b0;
    tick();
    HRDATA_S    = {D_A5, D_5A};
    HREADYOUT_S = 2'b11;
    HADDR  = 32'h2000_0000;
    HTRANS = T_NONSEQ;
    #1;
    checks++;
    if (HSEL_S !== 2'b10 || HREADY !== 1'b1) begin
      errors++;
      $display("FAIL rst_after_hsel: hsel=%b rdy=%b, want 10 1", HSEL_S, HREADY);
    end
    sb.push_back('{rdy: 1'b1, resp: 1'b0, data: D_A5});
    tick();
    HTRANS = T_IDLE;
    e = sb.pop_front();
    checks++;
    if (HREADY !== e.rdy || HRESP !== e.resp || HRDATA !== e.data) begin
      errors++;
      $display("FAIL rst_after_data: rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
               HREADY, HRESP, HRDATA, e.rdy, e.resp, e.data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_wait_states();
    test_error();
    test_overlap();
    test_reset_in_error();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
